// File: rtl/usb_pkg.sv
// Shared types and constants for the USB full-speed transmit path.
// Optional internal CRC generation is enabled with USB_TX_CRC_EN.
package usb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_PID,
      ST_DATA,
      ST_CRC_LO,
      ST_CRC_HI,
      ST_EOP_SE0,
      ST_EOP_J
   } state_e;

   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;

   localparam logic [7:0]  SYNC_BYTE  = 8'h80;
   localparam logic [15:0] CRC16_POLY = 16'h8005;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   function automatic logic [15:0] rev16(input logic [15:0] v);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[i] = v[15-i];
      return r;
   endfunction

endpackage

// File: rtl/usb_crc16.sv
// Bit-serial USB CRC16 over LSB-first data, kept in reflected form
// so the ones-complement goes out low byte first, LSB first.
module usb_crc16
   import usb_pkg::*;
(
   input  logic        clk,
   input  logic        n_rst,
   input  logic        clr,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   logic [15:0] crc_q, crc_d;
   logic        fb;

   always_comb begin
      crc_d = crc_q;
      fb    = crc_q[0] ^ din;
      if (clr) begin
         crc_d = CRC16_INIT;
      end else if (en) begin
         crc_d = {1'b0, crc_q[15:1]} ^ (fb ? rev16(CRC16_POLY) : 16'h0000);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) crc_q <= CRC16_INIT;
      else        crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/usb_tx_controller.sv
// USB full-speed TX packet sequencer: SYNC, PID, payload, CRC16, EOP.
// USB_TX_CRC_EN selects internal CRC; otherwise CRC bytes come from the FIFO.
module usb_tx_controller
   import usb_pkg::*;
#(
   parameter int CLKS_PER_BIT = 8,
   parameter int MAX_LEN      = 64
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       tx_start,
   input  logic [3:0] tx_pid,
   input  logic [6:0] tx_len,
   input  logic [7:0] fifo_data,
   input  logic       fifo_empty,
   input  logic       stuff_active,
   output logic       fifo_read,
   output logic       serial_out,
   output logic       shift_strobe,
   output logic       eop,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
`ifdef USB_TX_CRC_EN
   localparam state_e AFTER_DATA = ST_CRC_LO;
`else
   localparam state_e AFTER_DATA = ST_EOP_SE0;
`endif

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [6:0]    shreg_q, shreg_d;
   logic [6:0]    len_q, len_d;
   logic [6:0]    bytecnt_q, bytecnt_d;
   logic [3:0]    pid_q, pid_d;
   logic          so_q, so_d;
   logic          strobe_q, strobe_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [7:0]    ld;

   logic busy, start_ok, adv, byte_end, is_data, more;
   logic data_bnd, load_data, underrun;

   assign busy      = state_q != ST_IDLE;
   assign start_ok  = tx_start && !busy;
   assign adv       = busy && timer_q == T_LAST && !stuff_active;
   assign byte_end  = adv && bitcnt_q == 3'd7;
   assign is_data   = pid_q[1:0] == 2'b11;
   assign more      = bytecnt_q != len_q;
   assign data_bnd  = byte_end && is_data && more
                      && (state_q == ST_PID || state_q == ST_DATA);
   assign load_data = data_bnd && !fifo_empty;
   assign underrun  = data_bnd && fifo_empty;

`ifdef USB_TX_CRC_EN
   logic        crc_en, crc_bit;
   logic [15:0] crc;

   // CRC absorbs each payload bit as it is put on the line
   assign crc_en  = load_data
                    || (adv && state_q == ST_DATA && bitcnt_q != 3'd7);
   assign crc_bit = load_data ? fifo_data[0] : shreg_q[0];

   usb_crc16 u_crc (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (start_ok),
      .en    (crc_en),
      .din   (crc_bit),
      .crc   (crc)
   );
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (tx_start) state_d = ST_SYNC;
         ST_SYNC:    if (byte_end) state_d = ST_PID;
         ST_PID,
         ST_DATA: begin
            if (byte_end) begin
               if (state_q == ST_PID && !is_data) state_d = ST_EOP_SE0;
               else if (!more)                    state_d = AFTER_DATA;
               else if (fifo_empty)               state_d = ST_EOP_SE0;
               else                               state_d = ST_DATA;
            end
         end
         ST_CRC_LO:  if (byte_end) state_d = ST_CRC_HI;
         ST_CRC_HI:  if (byte_end) state_d = ST_EOP_SE0;
         ST_EOP_SE0: if (adv && bitcnt_q[0]) state_d = ST_EOP_J;
         ST_EOP_J:   if (adv) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      timer_d   = timer_q;
      bitcnt_d  = bitcnt_q;
      shreg_d   = shreg_q;
      len_d     = len_q;
      bytecnt_d = bytecnt_q;
      pid_d     = pid_q;
      so_d      = so_q;
      strobe_d  = 1'b0;
      done_d    = 1'b0;
      err_d     = err_q;
      ld        = 8'hFF;
      if (!busy) begin
         timer_d = '0;
         if (tx_start) begin
            pid_d     = tx_pid;
            len_d     = (tx_len > 7'(MAX_LEN)) ? 7'(MAX_LEN) : tx_len;
            bytecnt_d = '0;
            bitcnt_d  = '0;
            err_d     = 1'b0;
            so_d      = SYNC_BYTE[0];
            shreg_d   = SYNC_BYTE[7:1];
            strobe_d  = 1'b1;
         end
      end else begin
         timer_d = (timer_q == T_LAST) ? '0 : timer_q + 1'b1;
         if (underrun) err_d = 1'b1;
         if (adv) begin
            strobe_d = 1'b1;
            bitcnt_d = bitcnt_q + 3'd1;
            so_d     = shreg_q[0];
            shreg_d  = {1'b1, shreg_q[6:1]};
            // New byte or new state: reload the shifter from ld
            if (state_d != state_q || load_data) begin
               bitcnt_d = '0;
               unique case (state_d)
                  ST_PID:  ld = {~pid_q, pid_q};
                  ST_DATA: begin
                     ld        = fifo_data;
                     bytecnt_d = bytecnt_q + 7'd1;
                  end
`ifdef USB_TX_CRC_EN
                  ST_CRC_LO: ld = ~crc[7:0];
                  ST_CRC_HI: ld = ~crc[15:8];
`endif
                  ST_IDLE: begin
                     strobe_d = 1'b0;
                     done_d   = 1'b1;
                  end
                  default: ld = 8'hFF;
               endcase
               so_d    = ld[0];
               shreg_d = ld[7:1];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         timer_q   <= '0;
         bitcnt_q  <= '0;
         shreg_q   <= '1;
         len_q     <= '0;
         bytecnt_q <= '0;
         pid_q     <= '0;
         so_q      <= 1'b1;
         strobe_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         timer_q   <= timer_d;
         bitcnt_q  <= bitcnt_d;
         shreg_q   <= shreg_d;
         len_q     <= len_d;
         bytecnt_q <= bytecnt_d;
         pid_q     <= pid_d;
         so_q      <= so_d;
         strobe_q  <= strobe_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      eop          = state_q == ST_EOP_SE0;
      tx_busy      = busy;
      fifo_read    = load_data;
      serial_out   = so_q;
      shift_strobe = strobe_q;
      tx_done      = done_q;
      tx_error     = err_q;
   end

endmodule
